// File: rtl/regfile_access_ctrl_pkg.sv
// regfile_access_ctrl_pkg: command encodings, FSM states and defaults shared by the
// register-file access controller and the SoC control path that feeds it.
package regfile_access_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_READ        = 2'b00,
        OP_WRITE       = 2'b01,
        OP_FAULT_WRITE = 2'b10,
        OP_DUMP        = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HALT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_READ   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    localparam int STOP_SETTLE_DEFAULT = 2;

endpackage

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: halts the core, then reads, writes, fault-injects or dumps the
// register file through its debug port, releasing the core after the last response.
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int REG_ADDR_WIDTH     = 5,
    parameter int NUM_REGS           = 32,
    parameter int STOP_SETTLE_CYCLES = STOP_SETTLE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [REG_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic [REG_ADDR_WIDTH-1:0] rsp_addr,
    output logic                      rsp_last,
    output logic                      cpu_stop,
    input  logic                      cpu_idle,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr,
    output logic                      rf_we,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    input  logic [DATA_WIDTH-1:0]     rf_rdata
);

    localparam int CW = (STOP_SETTLE_CYCLES > 1) ? $clog2(STOP_SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((STOP_SETTLE_CYCLES > 0) ? STOP_SETTLE_CYCLES - 1 : 0);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_LAST = REG_ADDR_WIDTH'(NUM_REGS - 1);

    state_e                    state, state_n;
    op_e                       op_q;
    logic [REG_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DATA_WIDTH-1:0]     rsp_q;
    logic [CW-1:0]             cnt_q;
    logic                      stop_q;
    logic                      addr_zero;
    logic                      last_reg;
    logic [DATA_WIDTH-1:0]     rd_cap;
    state_e                    access_st;

    assign addr_zero = (addr_q == '0);
    assign last_reg  = (addr_q == ADDR_LAST);
    // x0 is hardwired zero regardless of what the debug read port returns
    assign rd_cap    = addr_zero ? '0 : rf_rdata;
    assign access_st = (op_q == OP_WRITE) ? ST_WRITE : ST_READ;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   state_n = cmd_valid ? ST_HALT : ST_IDLE;
            ST_HALT:   state_n = !cpu_idle ? ST_HALT : (STOP_SETTLE_CYCLES == 0) ? access_st : ST_SETTLE;
            ST_SETTLE: state_n = (cnt_q == CNT_LAST) ? access_st : ST_SETTLE;
            ST_READ:   state_n = (op_q == OP_FAULT_WRITE) ? ST_WRITE : ST_RESP;
            ST_WRITE:  state_n = ST_RESP;
            ST_RESP:   state_n = !rsp_ready ? ST_RESP : (op_q == OP_DUMP && !last_reg) ? ST_READ : ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= OP_READ;
            addr_q <= '0;
            data_q <= '0;
            rsp_q  <= '0;
            cnt_q  <= '0;
            stop_q <= 1'b0;
        end else begin
            state  <= state_n;
            stop_q <= (state_n != ST_IDLE);
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    op_q   <= op_e'(cmd_op);
                    addr_q <= (op_e'(cmd_op) == OP_DUMP) ? '0 : cmd_addr;
                    data_q <= cmd_wdata;
                end
                ST_HALT:   cnt_q <= '0;
                ST_SETTLE: cnt_q <= cnt_q + 1'b1;
                ST_READ: begin
                    rsp_q <= rd_cap;
                    if (op_q == OP_FAULT_WRITE) data_q <= rd_cap ^ data_q;
                end
                ST_WRITE: rsp_q <= addr_zero ? '0 : data_q;
                ST_RESP: if (rsp_ready && op_q == OP_DUMP && !last_reg) addr_q <= addr_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign cpu_stop  = stop_q;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_data  = rsp_valid ? rsp_q : '0;
    assign rsp_addr  = rsp_valid ? addr_q : '0;
    assign rsp_last  = rsp_valid && (op_q != OP_DUMP || last_reg);
    assign rf_addr   = (state == ST_READ || state == ST_WRITE) ? addr_q : '0;
    assign rf_we     = (state == ST_WRITE) && !addr_zero;
    assign rf_wdata  = (state == ST_WRITE) ? data_q : '0;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed checks of the register-file access controller against
// a behavioural register file with a combinational debug read port.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_addr;
    logic        rsp_last;
    logic        cpu_stop;
    logic        cpu_idle = 1'b0;
    logic [4:0]  rf_addr;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;

    logic [31:0] regs [32];
    logic        pre_req = 1'b0;
    logic        pre_dump = 1'b0;
    int          we_cnt = 0;
    logic [31:0] last_wdata = '0;
    int          n_vec = 0;
    int          n_err = 0;

    regfile_access_ctrl u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_last(rsp_last),
        .cpu_stop(cpu_stop), .cpu_idle(cpu_idle),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // x0 holds junk so the bench proves the controller masks it
    assign rf_rdata = regs[rf_addr];

    always @(posedge clk) begin
        if (pre_req) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= (i == 0) ? 32'hBAD0_0000 : pre_dump ? 32'(i * 4) :
                           (i == 5) ? 32'hDEAD_BEEF : (i == 3) ? 32'h0000_00F0 : 32'h0;
        end else if (rf_we) begin
            regs[rf_addr] <= rf_wdata;
            we_cnt = we_cnt + 1;
            last_wdata = rf_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic dump_pat);
        @(negedge clk);
        pre_dump = dump_pat;
        pre_req = 1'b1;
        @(negedge clk);
        pre_req = 1'b0;
    endtask

    // returns in cycle T+1 of the accept
    task automatic issue(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wd);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_addr = addr;
        cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int k;
        int w0;
        #2;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_cpu_stop", {31'd0, cpu_stop}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        preload(1'b0);

        // READ x5 with the core slow to go idle
        issue(2'b00, 5'd5, 32'h0);
        chk("rd5_stop_t1", {31'd0, cpu_stop}, 32'd1);
        chk("rd5_busy", {31'd0, cmd_ready}, 32'd0);
        repeat (10) @(negedge clk);
        chk("rd5_wait_idle", {31'd0, rsp_valid}, 32'd0);
        cpu_idle = 1'b1;
        wait_rsp(lat);
        chk("rd5_data", rsp_data, 32'hDEAD_BEEF);
        chk("rd5_addr", {27'd0, rsp_addr}, 32'd5);
        chk("rd5_last", {31'd0, rsp_last}, 32'd1);
        ack();
        chk("rd5_stop_fall", {31'd0, cpu_stop}, 32'd0);
        chk("rd5_ready_back", {31'd0, cmd_ready}, 32'd1);

        // WRITE x7, then READ it back
        w0 = we_cnt;
        issue(2'b01, 5'd7, 32'h1234_5678);
        wait_rsp(lat);
        chk("wr7_latency", lat, 32'd4);
        chk("wr7_we_count", we_cnt - w0, 32'd1);
        chk("wr7_rsp", rsp_data, 32'h1234_5678);
        ack();
        issue(2'b00, 5'd7, 32'h0);
        wait_rsp(lat);
        chk("rd7_latency", lat, 32'd4);
        chk("rd7_data", rsp_data, 32'h1234_5678);
        ack();

        // FAULT_WRITE x3: 0xF0 ^ 0x11
        w0 = we_cnt;
        issue(2'b10, 5'd3, 32'h0000_0011);
        wait_rsp(lat);
        chk("fw3_latency", lat, 32'd5);
        chk("fw3_we_count", we_cnt - w0, 32'd1);
        chk("fw3_wdata", last_wdata, 32'h0000_00E1);
        chk("fw3_rsp", rsp_data, 32'h0000_00E1);
        chk("fw3_reg", regs[3], 32'h0000_00E1);
        ack();

        // x0 is not writable and reads as zero
        w0 = we_cnt;
        issue(2'b01, 5'd0, 32'hFFFF_FFFF);
        wait_rsp(lat);
        chk("wr0_no_we", we_cnt - w0, 32'd0);
        chk("wr0_rsp", rsp_data, 32'd0);
        ack();
        issue(2'b00, 5'd0, 32'h0);
        wait_rsp(lat);
        chk("rd0_data", rsp_data, 32'd0);
        chk("rd0_addr", {27'd0, rsp_addr}, 32'd0);
        ack();

        // full dump with random back-pressure; cmd_addr must be ignored
        preload(1'b1);
        w0 = we_cnt;
        issue(2'b11, 5'd9, 32'h0);
        for (int n = 0; n < 32; n++) begin
            wait_rsp(lat);
            chk("dump_addr", {27'd0, rsp_addr}, n);
            chk("dump_data", rsp_data, 32'(n * 4));
            chk("dump_last", {31'd0, rsp_last}, {31'd0, n == 31});
            k = $urandom_range(0, 2);
            repeat (k) @(negedge clk);
            if (k != 0) begin
                chk("dump_stall_valid", {31'd0, rsp_valid}, 32'd1);
                chk("dump_stall_data", rsp_data, 32'(n * 4));
                chk("dump_stall_addr", {27'd0, rsp_addr}, n);
            end
            ack();
        end
        chk("dump_done_stop", {31'd0, cpu_stop}, 32'd0);
        chk("dump_no_we", we_cnt - w0, 32'd0);

        // reset in the middle of a dump
        issue(2'b11, 5'd0, 32'h0);
        for (int n = 0; n < 12; n++) begin
            wait_rsp(lat);
            ack();
        end
        wait_rsp(lat);
        chk("mid_addr12", {27'd0, rsp_addr}, 32'd12);
        rst = 1'b1;
        #1;
        chk("mid_stop_drop", {31'd0, cpu_stop}, 32'd0);
        chk("mid_valid_drop", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_ready_rel", {31'd0, cmd_ready}, 32'd1);
        issue(2'b00, 5'd9, 32'h0);
        chk("post_stop_t1", {31'd0, cpu_stop}, 32'd1);
        wait_rsp(lat);
        chk("post_latency", lat, 32'd4);
        chk("post_data", rsp_data, 32'd36);
        chk("post_last", {31'd0, rsp_last}, 32'd1);
        ack();
        chk("post_stop_fall", {31'd0, cpu_stop}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
